// File: rtl/fft_agu.sv
// Address generation unit and stage sequencer for an in-place radix-2 FFT (one butterfly per cycle).
// Optional stall input is enabled by defining AGU_STALL_EN.
module fft_agu #(
  parameter int N        = 512,
  parameter int M        = 9,
  parameter int PIPE_LAT = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
`ifdef AGU_STALL_EN
  input  logic         stall,
`endif
  output logic [M-1:0] rd_adr_a,
  output logic [M-1:0] rd_adr_b,
  output logic [M-2:0] twiddle_adr,
  output logic [M-1:0] wr_adr_a,
  output logic [M-1:0] wr_adr_b,
  output logic         we,
  output logic         bank_sel,
  output logic [3:0]   stage,
  output logic         busy,
  output logic         done
);

  localparam int           DW      = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [M-2:0] I_LAST  = (M-1)'(N/2 - 1);
  localparam logic [M-2:0] I_ONE   = (M-1)'(1);
  localparam logic [M-2:0] TW_ONES = '1;
  localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT - 1);
  localparam logic [DW-1:0] D_ONE  = DW'(1);
  localparam logic [3:0]   S_LAST  = 4'(M - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [M-2:0]  r_i;
  logic [3:0]    r_s;
  logic [DW-1:0] r_d;
  logic          r_bank;
  logic [M-1:0]  r_rd_a;
  logic [M-1:0]  r_rd_b;
  logic [M-2:0]  r_tw;
  logic [M-1:0]  r_dl_a [PIPE_LAT];
  logic [M-1:0]  r_dl_b [PIPE_LAT];
  logic          r_dl_v [PIPE_LAT];
  logic          w_stall;
  logic          w_run;
  logic [M-2:0]  w_i_inc;
  logic [3:0]    w_s_inc;

`ifdef AGU_STALL_EN
  assign w_stall = stall;
`else
  assign w_stall = 1'b0;
`endif

  // Stall freezes everything except an idle unit waiting for start.
  assign w_run   = ~w_stall | (r_state == S_IDLE);
  assign w_i_inc = r_i + I_ONE;
  assign w_s_inc = r_s + 4'd1;

  function automatic logic [M-1:0] rotl(input logic [M-1:0] x, input logic [3:0] sh);
    logic [2*M-1:0] w_d;
    w_d = {x, x} << sh;
    return w_d[2*M-1:M];
  endfunction

  function automatic logic [M-2:0] tw_of(input logic [M-2:0] idx, input logic [3:0] sh);
    logic [M-2:0] w_mask;
    w_mask = TW_ONES << (M - 1 - int'(sh));
    return idx & w_mask;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_run) begin
      case (r_state)
        S_IDLE:  if (start) w_state_next = S_ISSUE;
        S_ISSUE: if (r_i == I_LAST) w_state_next = S_DRAIN;
        S_DRAIN: if (r_d == D_LAST) w_state_next = (r_s == S_LAST) ? S_DONE : S_ISSUE;
        S_DONE:  w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    done = (r_state == S_DONE);
  end

  // Read addresses are loaded for the butterfly that will be presented next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_i    <= '0;
      r_s    <= '0;
      r_d    <= '0;
      r_bank <= 1'b0;
      r_rd_a <= '0;
      r_rd_b <= '0;
      r_tw   <= '0;
    end else if (w_run) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_i    <= '0;
            r_s    <= '0;
            r_d    <= '0;
            r_bank <= 1'b0;
            r_rd_a <= M'(0);
            r_rd_b <= M'(1);
            r_tw   <= '0;
          end
        end
        S_ISSUE: begin
          if (r_i == I_LAST) begin
            r_d <= '0;
          end else begin
            r_i    <= w_i_inc;
            r_rd_a <= rotl({w_i_inc, 1'b0}, r_s);
            r_rd_b <= rotl({w_i_inc, 1'b1}, r_s);
            r_tw   <= tw_of(w_i_inc, r_s);
          end
        end
        S_DRAIN: begin
          if (r_d == D_LAST) begin
            if (r_s != S_LAST) begin
              r_s    <= w_s_inc;
              r_i    <= '0;
              r_bank <= ~r_bank;
              r_rd_a <= rotl(M'(0), w_s_inc);
              r_rd_b <= rotl(M'(1), w_s_inc);
              r_tw   <= '0;
            end
          end else begin
            r_d <= r_d + D_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Write-back delay line matching the butterfly pipeline latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < PIPE_LAT; k++) begin
        r_dl_a[k] <= '0;
        r_dl_b[k] <= '0;
        r_dl_v[k] <= 1'b0;
      end
    end else if (!w_stall) begin
      r_dl_a[0] <= r_rd_a;
      r_dl_b[0] <= r_rd_b;
      r_dl_v[0] <= (r_state == S_ISSUE);
      for (int k = 1; k < PIPE_LAT; k++) begin
        r_dl_a[k] <= r_dl_a[k-1];
        r_dl_b[k] <= r_dl_b[k-1];
        r_dl_v[k] <= r_dl_v[k-1];
      end
    end
  end

  assign rd_adr_a    = r_rd_a;
  assign rd_adr_b    = r_rd_b;
  assign twiddle_adr = r_tw;
  assign bank_sel    = r_bank;
  assign stage       = r_s;
  assign wr_adr_a    = r_dl_a[PIPE_LAT-1];
  assign wr_adr_b    = r_dl_b[PIPE_LAT-1];
  assign we          = r_dl_v[PIPE_LAT-1] & ~w_stall;

endmodule

// File: tb/tb_fft_agu.sv
// Scoreboard bench for fft_agu: expected butterflies are queued at start, a monitor checks each write.
module tb_fft_agu;
  localparam int N = 512, M = 9, PL = 3, HALF = N / 2, STG = HALF + PL, TOTAL = M * STG;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         stall_tb = 1'b0;
  logic [M-1:0] rd_adr_a, rd_adr_b, wr_adr_a, wr_adr_b;
  logic [M-2:0] twiddle_adr;
  logic         we, bank_sel, busy, done;
  logic [3:0]   stage;

  fft_agu #(.N(N), .M(M), .PIPE_LAT(PL)) dut (
    .clk(clk), .reset(reset), .start(start),
`ifdef AGU_STALL_EN
    .stall(stall_tb),
`endif
    .rd_adr_a(rd_adr_a), .rd_adr_b(rd_adr_b), .twiddle_adr(twiddle_adr),
    .wr_adr_a(wr_adr_a), .wr_adr_b(wr_adr_b), .we(we), .bank_sel(bank_sel),
    .stage(stage), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { int s; int i; int ra; int rb; int tw; } bfly_t;
  typedef struct { int ra; int rb; int tw; int bank; int stg; } smp_t;

  bfly_t exp_q[$];
  int    exp_done_q[$];
  smp_t  hist[$];
  int    n_vec = 0, n_err = 0;
  int    cyc = 0;

  // Reference: read pair is the M-bit rotation of (2i, 2i+1) by s; twiddle keeps the top s bits of i.
  function automatic bfly_t model(int s, int i);
    bfly_t b;
    int x;
    b.s = s;
    b.i = i;
    x = 2 * i;
    b.ra = ((x << s) | (x >> (M - s))) % N;
    x = 2 * i + 1;
    b.rb = ((x << s) | (x >> (M - s))) % N;
    b.tw = (i >> (M - 1 - s)) << (M - 1 - s);
    return b;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    bfly_t b;
    smp_t  h;
    if (!reset) begin
      if (!stall_tb) begin
        hist.push_back('{int'(rd_adr_a), int'(rd_adr_b), int'(twiddle_adr), int'(bank_sel), int'(stage)});
        if (hist.size() > 8) void'(hist.pop_front());
      end
      if (we) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_we cyc=%0d got wr=%0d/%0d required no write", cyc, wr_adr_a, wr_adr_b);
        end else begin
          b = exp_q.pop_front();
          if (hist.size() > PL) h = hist[hist.size() - 1 - PL];
          else h = '{-1, -1, -1, -1, -1};
          if (int'(wr_adr_a) != b.ra || int'(wr_adr_b) != b.rb || h.ra != b.ra || h.rb != b.rb ||
              h.tw != b.tw || h.bank != (b.s % 2) || h.stg != b.s) begin
            n_err++;
            $display("FAIL bfly s=%0d i=%0d got wr=%0d/%0d rd=%0d/%0d tw=%0d bank=%0d stg=%0d required wr=rd=%0d/%0d tw=%0d bank=%0d",
                     b.s, b.i, wr_adr_a, wr_adr_b, h.ra, h.rb, h.tw, h.bank, h.stg, b.ra, b.rb, b.tw, b.s % 2);
          end
        end
      end
      if (done) begin
        n_vec++;
        if (exp_done_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_done cyc=%0d got done=1 required 0", cyc);
        end else if (cyc != exp_done_q[0] || exp_q.size() != 0 || busy) begin
          n_err++;
          $display("FAIL done_timing got cyc=%0d pending=%0d busy=%0d required cyc=%0d pending=0 busy=0",
                   cyc, exp_q.size(), busy, exp_done_q[0]);
          void'(exp_done_q.pop_front());
        end else begin
          void'(exp_done_q.pop_front());
        end
      end
    end
  end

  task automatic check_zero(string name);
    n_vec++;
    if (rd_adr_a != 0 || rd_adr_b != 0 || twiddle_adr != 0 || wr_adr_a != 0 || wr_adr_b != 0 ||
        we || bank_sel || stage != 0 || busy || done) begin
      n_err++;
      $display("FAIL %s got rd=%0d/%0d tw=%0d wr=%0d/%0d we=%0d bank=%0d stg=%0d busy=%0d done=%0d required all 0",
               name, rd_adr_a, rd_adr_b, twiddle_adr, wr_adr_a, wr_adr_b, we, bank_sel, stage, busy, done);
    end
  endtask

  // Issues one transform; returns with cyc == t0 (first ISSUE cycle).
  task automatic launch(output int t0, input int extra);
    int gap;
    gap = $urandom_range(0, 4);
    for (int k = 0; k < gap; k++) @(posedge clk) #1;
    start = 1'b1;
    t0 = cyc + 1;
    for (int s = 0; s < M; s++)
      for (int i = 0; i < HALF; i++) exp_q.push_back(model(s, i));
    exp_done_q.push_back(t0 + TOTAL + extra);
    @(posedge clk) #1;
    start = 1'b0;
    n_vec++;
    if (rd_adr_a != 0 || rd_adr_b != 1 || twiddle_adr != 0 || bank_sel || !busy || stage != 0) begin
      n_err++;
      $display("FAIL cycle0 got rd=%0d/%0d tw=%0d bank=%0d busy=%0d stg=%0d required 0/1 tw=0 bank=0 busy=1 stg=0",
               rd_adr_a, rd_adr_b, twiddle_adr, bank_sel, busy, stage);
    end
  endtask

  task automatic run_one(input bit do_stall);
    int t0, extra;
    extra = 0;
`ifdef AGU_STALL_EN
    if (do_stall) extra = 10;
`endif
    launch(t0, extra);
    for (int k = 0; k < TOTAL + 60 && exp_done_q.size() != 0; k++) begin
      @(posedge clk) #1;
      start = ($urandom_range(0, 49) == 0);
`ifdef AGU_STALL_EN
      stall_tb = do_stall && (cyc >= t0 + 2 * STG + 40) && (cyc < t0 + 2 * STG + 50);
`endif
    end
    start = 1'b0;
    stall_tb = 1'b0;
    n_vec++;
    if (exp_done_q.size() != 0 || busy || done) begin
      n_err++;
      $display("FAIL back_to_idle got pending_done=%0d busy=%0d done=%0d required 0/0/0",
               exp_done_q.size(), busy, done);
      exp_q.delete();
      exp_done_q.delete();
    end
  endtask

  task automatic mid_reset();
    int t0;
    launch(t0, 0);
    for (int k = 0; k < TOTAL && cyc < t0 + 4 * STG + 100; k++) @(posedge clk) #1;
    #1 reset = 1'b1;
    #1 check_zero("async_reset");
    exp_q.delete();
    exp_done_q.delete();
    hist.delete();
    @(posedge clk) #1;
    @(posedge clk) #1;
    reset = 1'b0;
    for (int k = 0; k < 8; k++) @(posedge clk) #1;
    check_zero("idle_after_reset");
  endtask

  initial begin
    #2 check_zero("reset_state");
    @(posedge clk) #1;
    @(posedge clk) #1;
    reset = 1'b0;
    @(posedge clk) #1;
    check_zero("idle_state");
    run_one(1'b0);
    mid_reset();
    run_one(1'b1);
    for (int k = 0; k < 4; k++) @(posedge clk) #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
